// File: rtl/lfsr_led_fader.sv
// LED fader: accepts a 4-bit target brightness over valid/ready, ramps a PWM
// level toward it one step per STEP_PERIODS PWM periods, dwells, then asks for more.
module lfsr_led_fader #(
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_PERIODS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       led,
  output logic [3:0] level,
  output logic       busy
);

  localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_FADE,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [3:0]        pwm_cnt_q;
  logic [3:0]        pwm_cnt_d;
  logic              led_q;
  logic              led_d;
  logic [3:0]        level_q;
  logic [3:0]        target_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              period_end;
  logic [3:0]        level_next;

  assign period_end = (pwm_cnt_q == 4'd15);
  assign pwm_cnt_d  = pwm_cnt_q + 4'd1;
  assign led_d      = (pwm_cnt_q < level_q);

  // FADE is only entered with level_q != target_q, so this never wraps.
  assign level_next = (target_q > level_q) ? level_q + 4'd1 : level_q - 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT;
      level_q    <= 4'd0;
      target_q   <= 4'd0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (sample_valid) begin
            target_q   <= sample;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            state_q    <= (sample == level_q) ? S_HOLD : S_FADE;
          end
        end
        S_FADE: begin
          // Level moves only on a period boundary, so no PWM period is truncated.
          if (period_end) begin
            if (step_cnt_q == STEP_LAST) begin
              level_q    <= level_next;
              step_cnt_q <= '0;
              if (level_next == target_q) begin
                state_q    <= S_HOLD;
                hold_cnt_q <= '0;
              end
            end else begin
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (period_end) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q <= S_WAIT;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign sample_ready = (state_q == S_WAIT);
  assign busy         = (state_q != S_WAIT);
  assign led          = led_q;
  assign level        = level_q;

endmodule

// File: tb/tb_lfsr_led_fader.sv
// Directed bench for lfsr_led_fader at default parameters: fades, holds,
// duty cycle, ignored busy-time input and mid-fade reset.
module tb_lfsr_led_fader;

  localparam int STEP = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sample = 4'd0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       led;
  logic [3:0] level;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected PWM phase: zero on every reset edge, then free-running.
  logic [3:0] tb_pwm = 4'd0;

  lfsr_led_fader #(
    .STEP_PERIODS(STEP),
    .HOLD_PERIODS(HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .led         (led),
    .level       (level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_pwm <= rst ? 4'd0 : tb_pwm + 4'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one sample for a single clock edge; ready must already be high.
  task automatic send(input logic [3:0] v);
    check("ready_before_send", {31'd0, sample_ready}, 1);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, sample_ready}, 0);
    check("busy_after_accept", {31'd0, busy}, 1);
  endtask

  // Follows a fade from 'from' to 'to' and the following hold until ready
  // returns. With spam set, drives valid=1/sample=0 every busy cycle.
  task automatic fade_hold(input logic [3:0] from, input logic [3:0] to, input bit spam);
    int         pe;
    int         steps;
    int         delta;
    int         budget;
    logic [3:0] prev;
    bit         in_hold;
    bit         done;
    pe      = 0;
    steps   = 0;
    delta   = (to > from) ? int'(to - from) : int'(from - to);
    budget  = (delta * STEP + HOLD + 2) * 16;
    prev    = from;
    in_hold = (from == to);
    done    = 1'b0;
    if (spam) begin
      sample       = 4'd0;
      sample_valid = 1'b1;
    end
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (tb_pwm == 4'd0) pe++;
      if (level !== prev) begin
        if (in_hold) begin
          check("hold_level_stable", {28'd0, level}, {28'd0, to});
          prev = level;
        end else begin
          check("step_direction", {28'd0, level},
                {28'd0, (to > prev) ? 4'(prev + 4'd1) : 4'(prev - 4'd1)});
          check("step_on_period_end", {28'd0, tb_pwm}, 0);
          check("step_spacing", pe, STEP);
          steps++;
          pe   = 0;
          prev = level;
          if (level == to) in_hold = 1'b1;
        end
      end
      if (sample_ready) begin
        sample_valid = 1'b0;
        check("steps_taken", steps, delta);
        check("hold_periods", pe, HOLD);
        check("final_level", {28'd0, level}, {28'd0, to});
        check("busy_in_wait", {31'd0, busy}, 0);
        done = 1'b1;
      end
    end
    if (!done) begin
      sample_valid = 1'b0;
      check("fade_timeout", 0, 1);
    end
  endtask

  // Counts led-high cycles over one 16-cycle window at a steady level.
  task automatic duty(input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led) hi++;
    end
    check("duty", hi, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_level", {28'd0, level}, 0);
    check("reset_led", {31'd0, led}, 0);
    check("reset_ready", {31'd0, sample_ready}, 1);
    check("reset_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("idle_level_led", {27'd0, level, led}, 0);
    end

    // Upward fade 0 -> 4 and its duty.
    send(4'd4);
    fade_hold(4'd0, 4'd4, 1'b0);
    duty(4);

    // Up to the top, then down to 2.
    send(4'd15);
    fade_hold(4'd4, 4'd15, 1'b0);
    duty(15);
    send(4'd2);
    fade_hold(4'd15, 4'd2, 1'b0);
    duty(2);

    // Reach 7, then an equal sample goes straight to HOLD.
    send(4'd7);
    fade_hold(4'd2, 4'd7, 1'b0);
    send(4'd7);
    fade_hold(4'd7, 4'd7, 1'b0);
    duty(7);

    // Busy-time valid with sample 0 must not disturb a fade toward 10.
    send(4'd10);
    fade_hold(4'd7, 4'd10, 1'b1);
    send(4'd0);
    fade_hold(4'd10, 4'd0, 1'b0);
    duty(0);

    // Reset pulse mid-fade at level 6.
    send(4'd12);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 12 * STEP * 16 && !hit; c++) begin
        @(negedge clk);
        if (level == 4'd6) hit = 1'b1;
      end
      check("reached_level_6", {31'd0, hit}, 1);
    end
    check("busy_mid_fade", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_level", {28'd0, level}, 0);
    check("midreset_led", {31'd0, led}, 0);
    check("midreset_ready", {31'd0, sample_ready}, 1);
    check("midreset_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_reset_idle", {26'd0, level, busy, led}, 0);
    end
    send(4'd3);
    fade_hold(4'd0, 4'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
